game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 32 +++
 rtl/game_flow_ctrl_frame_timer.sv | 37 +++
 rtl/game_flow_ctrl.sv | 142 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game sequencing types and the game_state codes consumed by the
// drawing mux and the per-screen drawers.
package game_pkg;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_PLAY    = 3'd1,
        S_RESPAWN = 3'd2,
        S_WIN     = 3'd3,
        S_OVER    = 3'd4
    } state_e;

    localparam logic [2:0] GS_START = 3'd1;
    localparam logic [2:0] GS_PLAY  = 3'd2;
    localparam logic [2:0] GS_WIN   = 3'd3;
    localparam logic [2:0] GS_OVER  = 3'd4;

    // Respawning is still "playing" as far as the screens are concerned.
    function automatic logic [2:0] state_to_code(state_e s);
        logic [2:0] code;
        case (s)
            S_START:   code = GS_START;
            S_PLAY:    code = GS_PLAY;
            S_RESPAWN: code = GS_PLAY;
            S_WIN:     code = GS_WIN;
            S_OVER:    code = GS_OVER;
            default:   code = GS_START;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Saturating frame counter; done pulses on the target-th tick after a clear.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] target,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Decoded from the current count only, so it never depends on clr and
    // the parent FSM can use it to decide its own transition without a loop.
    assign done = tick && (count_q == (target - W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns game_state, lives, level, respawn freeze
// and end-screen timeouts, and pulses new_game / level_start for the movers.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int NUM_LEVELS     = 2,
    parameter int RESPAWN_FRAMES = 60,
    parameter int END_FRAMES     = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame,
    input  logic       start_key,
    input  logic       player_hit,
    input  logic       level_clear,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [1:0] level,
    output logic       freeze,
    output logic       new_game,
    output logic       level_start
);

    localparam int TMAX = (RESPAWN_FRAMES > END_FRAMES) ? RESPAWN_FRAMES : END_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);

    state_e     state_q, state_d;
    logic [2:0] game_state_q, game_state_d;
    logic [1:0] lives_q, lives_d;
    logic [1:0] level_q, level_d;
    logic       freeze_q, freeze_d;
    logic       new_game_q, new_game_d;
    logic       level_start_q, level_start_d;
    logic       key_d_q;

    logic          key_edge;
    logic          timer_clr;
    logic          timer_done;
    logic [TW-1:0] timer_target;

    assign key_edge     = start_key && !key_d_q;
    assign timer_target = (state_q == S_RESPAWN) ? TW'(RESPAWN_FRAMES) : TW'(END_FRAMES);
    assign timer_clr    = (state_d != state_q);

    frame_timer #(
        .W (TW)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr),
        .tick   (start_of_frame),
        .target (timer_target),
        .done   (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        level_d       = level_q;
        new_game_d    = 1'b0;
        level_start_d = 1'b0;

        case (state_q)
            S_START: begin
                if (key_edge) begin
                    state_d       = S_PLAY;
                    lives_d       = 2'(LIVES_INIT);
                    level_d       = 2'd0;
                    new_game_d    = 1'b1;
                    level_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                // A hit in the same cycle as a clear wins; the clear is lost.
                if (player_hit) begin
                    if (lives_q == 2'd1) begin
                        state_d = S_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = S_RESPAWN;
                        lives_d = lives_q - 2'd1;
                    end
                end else if (level_clear) begin
                    if (level_q == 2'(NUM_LEVELS - 1)) begin
                        state_d = S_WIN;
                    end else begin
                        level_d       = level_q + 2'd1;
                        level_start_d = 1'b1;
                    end
                end
            end
            S_RESPAWN: begin
                if (timer_done) begin
                    state_d       = S_PLAY;
                    level_start_d = 1'b1;
                end
            end
            S_WIN, S_OVER: begin
                if (key_edge || timer_done) begin
                    state_d = S_START;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase

        game_state_d = state_to_code(state_d);
        freeze_d     = (state_d == S_RESPAWN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_START;
            game_state_q  <= GS_START;
            lives_q       <= 2'd0;
            level_q       <= 2'd0;
            freeze_q      <= 1'b0;
            new_game_q    <= 1'b0;
            level_start_q <= 1'b0;
            key_d_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            game_state_q  <= game_state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            freeze_q      <= freeze_d;
            new_game_q    <= new_game_d;
            level_start_q <= level_start_d;
            key_d_q       <= start_key;
        end
    end

    assign game_state  = game_state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign freeze      = freeze_q;
    assign new_game    = new_game_q;
    assign level_start = level_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural game model predicts the
// output vector for every cycle, and a monitor compares the DUT against it.
module tb_game_flow_ctrl;

    localparam int LIVES_INIT     = 3;
    localparam int NUM_LEVELS     = 2;
    localparam int RESPAWN_FRAMES = 60;
    localparam int END_FRAMES     = 180;

    logic       clk;
    logic       reset;
    logic       start_of_frame;
    logic       start_key;
    logic       player_hit;
    logic       level_clear;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [1:0] level;
    logic       freeze;
    logic       new_game;
    logic       level_start;

    int checks;
    int errors;

    // {game_state, lives, level, freeze, new_game, level_start}
    logic [9:0] exp_q[$];

    game_flow_ctrl #(
        .LIVES_INIT     (LIVES_INIT),
        .NUM_LEVELS     (NUM_LEVELS),
        .RESPAWN_FRAMES (RESPAWN_FRAMES),
        .END_FRAMES     (END_FRAMES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .start_key      (start_key),
        .player_hit     (player_hit),
        .level_clear    (level_clear),
        .game_state     (game_state),
        .lives          (lives),
        .level          (level),
        .freeze         (freeze),
        .new_game       (new_game),
        .level_start    (level_start)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // screen: 1 title, 2 playing, 3 won, 4 game over; respawning tracked apart.
    int m_screen;
    bit m_respawning;
    int m_lives;
    int m_level;
    int m_frames;
    bit m_prev_key;
    bit m_new_game;
    bit m_level_start;
    int cycle;

    task automatic model_step(input bit rst, input bit sof, input bit key,
                              input bit hit, input bit clr);
        bit edge_seen;
        int old_screen;
        bit old_resp;
        if (rst) begin
            m_screen      = 1;
            m_respawning  = 0;
            m_lives       = 0;
            m_level       = 0;
            m_frames      = 0;
            m_prev_key    = 1;
            m_new_game    = 0;
            m_level_start = 0;
        end else begin
            edge_seen     = key && !m_prev_key;
            m_prev_key    = key;
            m_new_game    = 0;
            m_level_start = 0;
            old_screen    = m_screen;
            old_resp      = m_respawning;
            if (m_screen == 1) begin
                if (edge_seen) begin
                    m_screen      = 2;
                    m_lives       = LIVES_INIT;
                    m_level       = 0;
                    m_new_game    = 1;
                    m_level_start = 1;
                end
            end else if (m_screen == 2 && m_respawning) begin
                if (sof && (m_frames + 1 == RESPAWN_FRAMES)) begin
                    m_respawning  = 0;
                    m_level_start = 1;
                end
            end else if (m_screen == 2) begin
                if (hit) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_screen = 4;
                    else m_respawning = 1;
                end else if (clr) begin
                    if (m_level + 1 == NUM_LEVELS) m_screen = 3;
                    else begin
                        m_level       = m_level + 1;
                        m_level_start = 1;
                    end
                end
            end else begin
                if (edge_seen || (sof && (m_frames + 1 == END_FRAMES))) m_screen = 1;
            end
            if (m_screen != old_screen || m_respawning != old_resp) m_frames = 0;
            else if (sof) m_frames = m_frames + 1;
        end
    endtask

    function automatic logic [9:0] model_outputs();
        logic [2:0] gs;
        logic [1:0] lv;
        logic [1:0] lvl;
        gs  = 3'(m_screen);
        lv  = 2'(m_lives);
        lvl = 2'(m_level);
        return {gs, lv, lvl, m_respawning, m_new_game, m_level_start};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit sof, input bit key,
                        input bit hit, input bit clr);
        @(negedge clk);
        reset          = rst;
        start_of_frame = sof;
        start_key      = key;
        player_hit     = hit;
        level_clear    = clr;
        model_step(rst, sof, key, hit, clr);
        exp_q.push_back(model_outputs());
        cycle++;
    endtask

    task automatic idle(input int n, input bit key);
        for (int i = 0; i < n; i++) step(0, 0, key, 0, 0);
    endtask

    // n frame pulses, each followed by a quiet cycle
    task automatic frames(input int n, input bit key);
        for (int i = 0; i < n; i++) begin
            step(0, 1, key, 0, 0);
            step(0, 0, key, 0, 0);
        end
    endtask

    task automatic press_key();
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {game_state, lives, level, freeze, new_game, level_start};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t {gs,lives,level,frz,ng,ls} actual=%0d,%0d,%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d,%0d,%0d",
                         $time, act[9:7], act[6:5], act[4:3], act[2], act[1], act[0],
                         exp[9:7], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        reset = 1'b1; start_of_frame = 1'b0; start_key = 1'b1;
        player_hit = 1'b0; level_clear = 1'b0;

        // key held through reset never starts a game
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        idle(10, 1);
        press_key();

        // lose a life, hit during freeze is ignored, respawn after 60 frames
        step(0, 0, 0, 1, 0);
        frames(10, 0);
        step(0, 0, 0, 1, 1);
        frames(RESPAWN_FRAMES - 10, 0);
        idle(3, 0);

        // clear both levels, then the win screen times out
        step(0, 0, 0, 0, 1);
        idle(2, 0);
        step(0, 0, 0, 0, 1);
        frames(END_FRAMES, 0);
        idle(3, 0);

        // new game, burn down to one life, then hit and clear together
        press_key();
        step(0, 0, 0, 1, 0);
        frames(RESPAWN_FRAMES, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        frames(RESPAWN_FRAMES, 0);
        step(0, 0, 0, 1, 1);
        idle(2, 0);

        // game over: key after 5 frames returns to title
        frames(5, 0);
        press_key();
        idle(2, 0);

        // key edge and final end frame in the same cycle: one transition
        press_key();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        frames(END_FRAMES - 1, 0);
        step(0, 1, 1, 0, 0);
        idle(3, 0);

        // reset during respawn
        press_key();
        step(0, 0, 0, 1, 0);
        frames(4, 0);
        step(1, 1, 0, 0, 0);
        idle(4, 0);

        // randomized play
        begin
            bit key;
            key = 0;
            for (int i = 0; i < 8000; i++) begin
                if ($urandom_range(0, 7) == 0) key = ~key;
                step($urandom_range(0, 999) == 0,
                     $urandom_range(0, 3) == 0,
                     key,
                     $urandom_range(0, 40) == 0,
                     $urandom_range(0, 25) == 0);
            end
        end

        // let the monitor drain, bounded
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
